// File: rtl/wb_cmd_master_pkg.sv
// ----------------------------------------------------------------------------
// wb_cmd_master_pkg
//   Shared types for the Wishbone command master: the FSM state encoding and
//   the response status codes returned on rsp_status.
// ----------------------------------------------------------------------------
package wb_cmd_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_ERR     = 2'd1,
        RSP_TIMEOUT = 2'd2
    } rsp_status_e;

endpackage

// File: rtl/wb_if.sv
// ----------------------------------------------------------------------------
// wb_if
//   Classic Wishbone bus bundle.
//   master modport : drives cyc/stb/we/adr/sel/dat_w, samples dat_r/ack/err
//   slave modport  : the reverse
//   There is no RTY line: a retry is indistinguishable from a slave that has
//   not answered yet, so it would only ever run into the timeout.
// ----------------------------------------------------------------------------
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic            ack;
    logic            err;

    modport master (output cyc, stb, we, adr, sel, dat_w,
                    input  dat_r, ack, err);
    modport slave  (input  cyc, stb, we, adr, sel, dat_w,
                    output dat_r, ack, err);
endinterface

// File: rtl/wb_cmd_master_fifo.sv
// ----------------------------------------------------------------------------
// wb_cmd_master_fifo
//   Synchronous show-ahead FIFO: o_data always presents the head entry, and a
//   pop consumes it at the same edge. DEPTH must be a power of two so the
//   pointers wrap naturally.
//   Ports: clk, rst_i (sync, active-high), i_push/i_data, i_pop/o_data,
//          o_full, o_empty, o_count (registered occupancy)
// ----------------------------------------------------------------------------
module wb_cmd_master_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Flags come from the registered count only, so a pop in the same cycle
    // never makes a full FIFO look ready.
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; emptiness is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/wb_cmd_master.sv
// ----------------------------------------------------------------------------
// wb_cmd_master
//   Wishbone initiator fed by a valid/ready command stream. Each command
//   becomes one classic single read/write cycle; exactly one response is
//   returned per command, in order. One bus transaction outstanding.
//   Ports:
//     clk, rst_i                     clock, sync active-high reset
//     cmd_valid/cmd_ready            command handshake
//     cmd_we/cmd_adr/cmd_dat/cmd_sel command payload
//     rsp_valid/rsp_ready            response handshake
//     rsp_dat/rsp_status             read data (0 unless OK read), 0/1/2 = OK/ERR/TIMEOUT
//     busy                           commands queued or transaction in progress
//     m                              Wishbone master port
// ----------------------------------------------------------------------------
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst_i,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_we,
    input  logic [WB_ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [WB_DATA_WIDTH-1:0]   cmd_dat,
    input  logic [WB_DATA_WIDTH/8-1:0] cmd_sel,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WB_DATA_WIDTH-1:0]   rsp_dat,
    output logic [1:0]                 rsp_status,
    output logic                       busy,
    wb_if.master                       m
);

    localparam int AW     = WB_ADDR_WIDTH;
    localparam int DW     = WB_DATA_WIDTH;
    localparam int SW     = WB_DATA_WIDTH / 8;
    localparam int CMD_W  = 1 + AW + DW + SW;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam int FCNT_W = $clog2(CMD_FIFO_DEPTH) + 1;

    state_e             r_state;
    logic               r_cyc;
    logic               r_stb;
    logic               r_we;
    logic [AW-1:0]      r_adr;
    logic [SW-1:0]      r_sel;
    logic [DW-1:0]      r_dat_w;
    logic               r_rsp_valid;
    logic [DW-1:0]      r_rsp_dat;
    rsp_status_e        r_rsp_status;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_full;
    logic               w_empty;
    logic [FCNT_W-1:0]  w_count;
    logic [CMD_W-1:0]   w_head;
    logic               w_head_we;
    logic [AW-1:0]      w_head_adr;
    logic [DW-1:0]      w_head_dat;
    logic [SW-1:0]      w_head_sel;
    logic               w_pop;
    logic               w_timeout;
    logic               w_bus_done;

    wb_cmd_master_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_i   (rst_i),
        .i_push  (cmd_valid && cmd_ready),
        .i_data  ({cmd_we, cmd_adr, cmd_dat, cmd_sel}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign {w_head_we, w_head_adr, w_head_dat, w_head_sel} = w_head;

    // A new command is launched from IDLE, or straight from RESP as the
    // previous response is consumed (leaving exactly one dead bus cycle).
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));

    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);
    assign w_bus_done = m.err || m.ack || w_timeout;

    assign cmd_ready  = !w_full;
    assign busy       = (w_count != '0) || (r_state != ST_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_dat    = r_rsp_dat;
    assign rsp_status = r_rsp_status;

    assign m.cyc   = r_cyc;
    assign m.stb   = r_stb;
    assign m.we    = r_we;
    assign m.adr   = r_adr;
    assign m.sel   = r_sel;
    assign m.dat_w = r_dat_w;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_adr        <= '0;
            r_sel        <= '0;
            r_dat_w      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_dat    <= '0;
            r_rsp_status <= RSP_OK;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) r_state <= ST_BUS;
                end
                ST_BUS: begin
                    if (w_bus_done) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_RESP;
                        // ERR outranks ACK, and either outranks an expiring timeout.
                        if (m.err) begin
                            r_rsp_status <= RSP_ERR;
                            r_rsp_dat    <= '0;
                        end else if (m.ack) begin
                            r_rsp_status <= RSP_OK;
                            r_rsp_dat    <= r_we ? '0 : m.dat_r;
                        end else begin
                            r_rsp_status <= RSP_TIMEOUT;
                            r_rsp_dat    <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= w_empty ? ST_IDLE : ST_BUS;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Bus launch shared by IDLE and RESP; never coincides with BUS.
            if (w_pop) begin
                r_cyc   <= 1'b1;
                r_stb   <= 1'b1;
                r_we    <= w_head_we;
                r_adr   <= w_head_adr;
                r_sel   <= w_head_sel;
                r_dat_w <= w_head_dat;
            end
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave behaviour knobs: respond when wcnt (cycles CYC has already been
    // high in this transaction) equals slv_wait; read data = adr ^ slv_xor.
    int          slv_wait;
    logic        slv_ack;
    logic        slv_err;
    logic [31:0] slv_xor;
    int          wcnt = 0;

    wb_if #(.AW(32), .DW(32)) bus ();

    wb_cmd_master #(
        .WB_ADDR_WIDTH  (32),
        .WB_DATA_WIDTH  (32),
        .CMD_FIFO_DEPTH (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_dat    (cmd_dat),
        .cmd_sel    (cmd_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_dat    (rsp_dat),
        .rsp_status (rsp_status),
        .busy       (busy),
        .m          (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.cyc) wcnt <= wcnt + 1;
        else         wcnt <= 0;
    end

    always_comb begin
        bus.ack   = 1'b0;
        bus.err   = 1'b0;
        bus.dat_r = 32'h0;
        if (bus.cyc && bus.stb && (wcnt == slv_wait)) begin
            bus.ack   = slv_ack;
            bus.err   = slv_err;
            bus.dat_r = bus.adr ^ slv_xor;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        n_cmp++;
        if ({bus.cyc, bus.stb, bus.we} !== 3'b000) begin
            n_bad++; $display("FAIL rst_cyc_stb_we got %b want 000", {bus.cyc, bus.stb, bus.we});
        end
        n_cmp++;
        if ({bus.adr, bus.sel, bus.dat_w} !== 68'h0) begin
            n_bad++; $display("FAIL rst_adr_sel_dat got %h want 0", {bus.adr, bus.sel, bus.dat_w});
        end
        n_cmp++;
        if ({rsp_valid, rsp_status, rsp_dat} !== 35'h0) begin
            n_bad++; $display("FAIL rst_rsp got %h want 0", {rsp_valid, rsp_status, rsp_dat});
        end
        n_cmp++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_bad++; $display("FAIL rst_ready_busy got %b want 10", {cmd_ready, busy});
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_write();
        rsp_ready = 1'b0; slv_wait = 0; slv_ack = 1'b1; slv_err = 1'b0; slv_xor = 32'h0;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL wr_ready got %b want 1", cmd_ready);
        end
        push_one(1'b1, 32'h8000_2000, 32'h5, 4'hF);
        n_cmp++;
        if (bus.cyc !== 1'b0) begin
            n_bad++; $display("FAIL wr_cyc_early got %b want 0", bus.cyc);
        end
        step();
        n_cmp++;
        if ({bus.cyc, bus.stb, bus.we} !== 3'b111) begin
            n_bad++; $display("FAIL wr_cyc_stb_we got %b want 111", {bus.cyc, bus.stb, bus.we});
        end
        n_cmp++;
        if ({bus.adr, bus.sel, bus.dat_w} !== {32'h8000_2000, 4'hF, 32'h5}) begin
            n_bad++; $display("FAIL wr_bus_fields got %h want %h", {bus.adr, bus.sel, bus.dat_w},
                              {32'h8000_2000, 4'hF, 32'h5});
        end
        step();
        n_cmp++;
        if ({bus.cyc, bus.stb} !== 2'b00) begin
            n_bad++; $display("FAIL wr_one_pulse got %b want 00", {bus.cyc, bus.stb});
        end
        n_cmp++;
        if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'd0, 32'h0}) begin
            n_bad++; $display("FAIL wr_rsp got %h want %h", {rsp_valid, rsp_status, rsp_dat},
                              {1'b1, 2'd0, 32'h0});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_cmp++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_bad++; $display("FAIL wr_after_rsp got %b want 00", {rsp_valid, busy});
        end
    endtask

    task automatic test_read_wait();
        logic stable;
        rsp_ready = 1'b0; slv_wait = 3; slv_ack = 1'b1; slv_err = 1'b0;
        slv_xor = 32'hDEAD_BEEF ^ 32'h1000_0004;
        push_one(1'b0, 32'h1000_0004, 32'h0, 4'hC);
        step();
        stable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (bus.cyc !== 1'b1 || bus.stb !== 1'b1 || bus.we !== 1'b0 ||
                bus.adr !== 32'h1000_0004 || bus.sel !== 4'hC) stable = 1'b0;
            step();
        end
        n_cmp++;
        if (stable !== 1'b1) begin
            n_bad++; $display("FAIL rd_stable_4cyc got %b want 1", stable);
        end
        n_cmp++;
        if ({bus.cyc, rsp_valid} !== 2'b01) begin
            n_bad++; $display("FAIL rd_end got cyc/rsp_valid %b want 01", {bus.cyc, rsp_valid});
        end
        n_cmp++;
        if ({rsp_status, rsp_dat} !== {2'd0, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL rd_data got %h want %h", {rsp_status, rsp_dat}, {2'd0, 32'hDEAD_BEEF});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        rsp_ready = 1'b0; slv_wait = 1000; slv_ack = 1'b1; slv_err = 1'b0; slv_xor = 32'h1111_0000;
        push_one(1'b0, 32'h2000_0000, 32'h0, 4'hF);
        step();
        n = 0;
        while (bus.cyc === 1'b1 && n < 40) begin n++; step(); end
        n_cmp++;
        if (n !== 16) begin
            n_bad++; $display("FAIL to_cyc_len got %0d want 16", n);
        end
        n_cmp++;
        if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'd2, 32'h0}) begin
            n_bad++; $display("FAIL to_rsp got %h want %h", {rsp_valid, rsp_status, rsp_dat},
                              {1'b1, 2'd2, 32'h0});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Follow-up command must see a cleared counter.
        slv_wait = 0;
        push_one(1'b0, 32'h2000_0010, 32'h0, 4'hF);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin n++; step(); end
        n_cmp++;
        if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'd0, 32'h3111_0010}) begin
            n_bad++; $display("FAIL to_next_ok got %h want %h", {rsp_valid, rsp_status, rsp_dat},
                              {1'b1, 2'd0, 32'h3111_0010});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // ACK on the 16th bus cycle wins over the expiring timeout.
        slv_wait = 15;
        push_one(1'b0, 32'h2000_0020, 32'h0, 4'hF);
        step();
        n = 0;
        while (bus.cyc === 1'b1 && n < 40) begin n++; step(); end
        n_cmp++;
        if (n !== 16) begin
            n_bad++; $display("FAIL to_ack_last_len got %0d want 16", n);
        end
        n_cmp++;
        if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'd0, 32'h3111_0020}) begin
            n_bad++; $display("FAIL to_ack_last got %h want %h", {rsp_valid, rsp_status, rsp_dat},
                              {1'b1, 2'd0, 32'h3111_0020});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_dat [5];
        int got;
        rsp_ready = 1'b0; slv_wait = 0; slv_ack = 1'b1; slv_err = 1'b0; slv_xor = 32'h0F0F_0000;
        for (int i = 0; i < 5; i++) begin
            exp_dat[i] = (32'h100 + 32'(4 * i)) ^ 32'h0F0F_0000;
            cmd_we = 1'b0; cmd_adr = 32'h100 + 32'(4 * i); cmd_dat = 32'h0; cmd_sel = 4'hF;
            cmd_valid = 1'b1;
            n_cmp++;
            if (cmd_ready !== 1'b1) begin
                n_bad++; $display("FAIL q_ready_%0d got %b want 1", i, cmd_ready);
            end
            step();
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b011) begin
            n_bad++; $display("FAIL q_full got ready/busy/rsp %b want 011", {cmd_ready, busy, rsp_valid});
        end
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (rsp_valid === 1'b1) begin
                n_cmp++;
                if ({rsp_status, rsp_dat} !== {2'd0, exp_dat[got]}) begin
                    n_bad++; $display("FAIL q_rsp_%0d got %h want %h", got, {rsp_status, rsp_dat},
                                      {2'd0, exp_dat[got]});
                end
                got++;
            end
            step();
        end
        rsp_ready = 1'b0;
        n_cmp++;
        if (got !== 5) begin
            n_bad++; $display("FAIL q_rsp_count got %0d want 5", got);
        end
        n_cmp++;
        if ({busy, rsp_valid, cmd_ready} !== 3'b001) begin
            n_bad++; $display("FAIL q_drained got busy/rsp/ready %b want 001", {busy, rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_ack_err();
        int n;
        rsp_ready = 1'b0; slv_wait = 1; slv_ack = 1'b1; slv_err = 1'b1; slv_xor = 32'h5555_0000;
        push_one(1'b0, 32'h4000_0000, 32'h0, 4'hF);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin n++; step(); end
        n_cmp++;
        if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'd1, 32'h0}) begin
            n_bad++; $display("FAIL ackerr_rsp got %h want %h", {rsp_valid, rsp_status, rsp_dat},
                              {1'b1, 2'd1, 32'h0});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        slv_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic quiet;
        int n;
        rsp_ready = 1'b0; slv_wait = 1000; slv_ack = 1'b1; slv_err = 1'b0; slv_xor = 32'h0000_00FF;
        for (int i = 0; i < 4; i++) begin
            cmd_we = 1'b1; cmd_adr = 32'h500 + 32'(i); cmd_dat = 32'(i); cmd_sel = 4'hF;
            cmd_valid = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if ({bus.cyc, busy} !== 2'b11) begin
            n_bad++; $display("FAIL rm_in_bus got cyc/busy %b want 11", {bus.cyc, busy});
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        n_cmp++;
        if ({bus.cyc, bus.stb, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
            n_bad++; $display("FAIL rm_after_rst got %b want 00001",
                              {bus.cyc, bus.stb, rsp_valid, busy, cmd_ready});
        end
        quiet = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (rsp_valid !== 1'b0 || bus.cyc !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_bad++; $display("FAIL rm_no_leftover got %b want 1", quiet);
        end
        slv_wait = 0;
        rsp_ready = 1'b1;
        push_one(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin n++; step(); end
        n_cmp++;
        if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'd0, 32'h3000_00FF}) begin
            n_bad++; $display("FAIL rm_next_cmd got %h want %h", {rsp_valid, rsp_status, rsp_dat},
                              {1'b1, 2'd0, 32'h3000_00FF});
        end
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0;
        cmd_sel = 4'h0; rsp_ready = 1'b0;
        slv_wait = 0; slv_ack = 1'b1; slv_err = 1'b0; slv_xor = 32'h0;
        test_reset();
        test_write();
        test_read_wait();
        test_timeout();
        test_back_to_back();
        test_ack_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
